// File: rtl/jzjpcc_memory_stage_port.sv
// jzjpcc_memory_stage_port: memory-stage load/store initiator on SRAM port B.
// Converts CPU byte order to SRAM lane order (byte at 4n+k in word n, bits
// [31-8k:24-8k]), builds byte write masks and returns extended load data one
// cycle after the final SRAM read.
// Optional build macro JZJPCC_MISALIGNED_SPLIT_EN: split misaligned accesses
// over two consecutive words instead of faulting them.
module jzjpcc_memory_stage_port #(
    parameter int unsigned RAM_A_WIDTH = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [2:0]             req_funct3,
    input  logic [31:0]            req_address,
    input  logic [31:0]            req_store_data,
    output logic                   resp_valid,
    output logic [31:0]            resp_load_data,
    output logic                   resp_fault,
    output logic [RAM_A_WIDTH-1:0] addressB,
    input  logic [31:0]            readB,
    output logic                   writeEnableB,
    output logic [3:0]             byteWriteMaskB,
    output logic [31:0]            writeB
);

`ifdef JZJPCC_MISALIGNED_SPLIT_EN
    typedef enum logic {IDLE, SECOND} state_t;
`else
    typedef enum logic {IDLE} state_t;
`endif

    state_t state, next_state;

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // request decode
    logic [1:0]             req_off;
    logic [RAM_A_WIDTH-1:0] req_word;
    logic [3:0]             size_mask;
    logic                   illegal;
    logic                   misaligned;
    logic                   fault_req;
    logic                   accept;
    logic                   write_now;
    logic [3:0]             mask_now;
    logic [31:0]            data_now;
    logic                   unused_addr_bits;

    assign req_off          = req_address[1:0];
    assign req_word         = req_address[RAM_A_WIDTH+1:2];
    assign unused_addr_bits = ^req_address[31:RAM_A_WIDTH+2];
    assign illegal          = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    assign misaligned       = ((req_funct3[1:0] == 2'b01) && req_off[0]) ||
                              ((req_funct3[1:0] == 2'b10) && (req_off != 2'b00));
    assign size_mask        = (req_funct3[1:0] == 2'b00) ? 4'b1000 :
                              (req_funct3[1:0] == 2'b01) ? 4'b1100 : 4'b1111;
    assign accept           = reset && req_valid && (state == IDLE);

`ifdef JZJPCC_MISALIGNED_SPLIT_EN
    // Upper half addresses word n, lower half spills into word n+1.
    logic [7:0]  lane_mask8;
    logic [63:0] lane_data64;
    logic        split_req;

    assign lane_mask8  = {size_mask, 4'b0000} >> req_off;
    assign lane_data64 = {bswap(req_store_data), 32'h0} >> {req_off, 3'b000};
    assign split_req   = misaligned && !illegal;
    assign fault_req   = illegal;
    assign mask_now    = lane_mask8[7:4];
    assign data_now    = lane_data64[63:32];

    logic [RAM_A_WIDTH-1:0] sec_word;
    logic                   sec_write;
    logic [3:0]             sec_mask;
    logic [31:0]            sec_data;
    logic [2:0]             sec_funct3;
    logic [1:0]             sec_off;
    logic                   rsp_split;
    logic [31:0]            lo_word;
`else
    assign fault_req = illegal || misaligned;
    assign mask_now  = size_mask >> req_off;
    assign data_now  = bswap(req_store_data) >> {req_off, 3'b000};
`endif

    assign write_now = accept && req_write && !fault_req;

    // response pipeline registers
    logic       rsp_pend;
    logic       rsp_fault;
    logic       rsp_load;
    logic [2:0] rsp_funct3;
    logic [1:0] rsp_off;

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // next state and SRAM port B drive
    always_comb begin
        next_state     = IDLE;
        req_ready      = (state == IDLE);
        addressB       = '0;
        writeEnableB   = 1'b0;
        byteWriteMaskB = '0;
        writeB         = '0;
        if (state == IDLE) begin
            if (accept) begin
                addressB = req_word;
                if (write_now) begin
                    writeEnableB   = 1'b1;
                    byteWriteMaskB = mask_now;
                    writeB         = data_now;
                end
`ifdef JZJPCC_MISALIGNED_SPLIT_EN
                if (split_req) next_state = SECOND;
`endif
            end
        end
`ifdef JZJPCC_MISALIGNED_SPLIT_EN
        else begin
            addressB = sec_word;
            if (sec_write) begin
                writeEnableB   = 1'b1;
                byteWriteMaskB = sec_mask;
                writeB         = sec_data;
            end
        end
`endif
    end

    // capture request attributes for the response and the second half
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_pend   <= 1'b0;
            rsp_fault  <= 1'b0;
            rsp_load   <= 1'b0;
            rsp_funct3 <= '0;
            rsp_off    <= '0;
`ifdef JZJPCC_MISALIGNED_SPLIT_EN
            rsp_split  <= 1'b0;
            lo_word    <= '0;
            sec_word   <= '0;
            sec_write  <= 1'b0;
            sec_mask   <= '0;
            sec_data   <= '0;
            sec_funct3 <= '0;
            sec_off    <= '0;
`endif
        end else begin
            rsp_pend  <= 1'b0;
            rsp_fault <= 1'b0;
`ifdef JZJPCC_MISALIGNED_SPLIT_EN
            if (state == SECOND) begin
                // readB now holds word n; word n+1 arrives next cycle
                rsp_pend   <= 1'b1;
                rsp_load   <= !sec_write;
                rsp_funct3 <= sec_funct3;
                rsp_off    <= sec_off;
                rsp_split  <= 1'b1;
                lo_word    <= readB;
            end else
`endif
            if (accept) begin
                rsp_load   <= !req_write;
                rsp_funct3 <= req_funct3;
                rsp_off    <= req_off;
`ifdef JZJPCC_MISALIGNED_SPLIT_EN
                rsp_pend   <= !split_req;
                rsp_fault  <= fault_req;
                rsp_split  <= 1'b0;
                sec_word   <= req_word + 1'b1;
                sec_write  <= req_write;
                sec_mask   <= lane_mask8[3:0];
                sec_data   <= lane_data64[31:0];
                sec_funct3 <= req_funct3;
                sec_off    <= req_off;
`else
                rsp_pend   <= 1'b1;
                rsp_fault  <= fault_req;
`endif
            end
        end
    end

    logic [4:0]  load_shift;
    logic [31:0] load_window;
    logic [31:0] load_cpu;

    assign load_shift = {rsp_off, 3'b000};
    assign resp_valid = rsp_pend;
    assign resp_fault = rsp_fault;

    // align, byte-swap and extend the returned load data
    always_comb begin
        load_window = readB << load_shift;
`ifdef JZJPCC_MISALIGNED_SPLIT_EN
        if (rsp_split)
            load_window = (lo_word << load_shift) | (readB >> (6'd32 - {1'b0, load_shift}));
`endif
        load_cpu       = bswap(load_window);
        resp_load_data = '0;
        if (rsp_pend && rsp_load && !rsp_fault) begin
            case (rsp_funct3)
                3'b000:  resp_load_data = {{24{load_cpu[7]}}, load_cpu[7:0]};
                3'b001:  resp_load_data = {{16{load_cpu[15]}}, load_cpu[15:0]};
                3'b010:  resp_load_data = load_cpu;
                3'b100:  resp_load_data = {24'h0, load_cpu[7:0]};
                3'b101:  resp_load_data = {16'h0, load_cpu[15:0]};
                default: resp_load_data = '0;
            endcase
        end
    end

endmodule
